// File: rtl/rst_seq_if.sv
// Purpose : signal bundle between the reset sequencer and its environment.
// Ports   : pll_lock, sw_rst_n, clk32k_in   -> sequencer inputs (asynchronous)
//           rst_n_out, sys_ready, lock_lost_cnt, clk32k_fault, state_o
//                                            <- sequencer status/reset outputs
// master drives the raw inputs and observes outputs; slave is the sequencer.
interface rst_seq_if #(
    parameter int unsigned NUM_STAGES = 3
) ();
    logic                  pll_lock;
    logic                  sw_rst_n;
    logic                  clk32k_in;
    logic [NUM_STAGES-1:0] rst_n_out;
    logic                  sys_ready;
    logic [7:0]            lock_lost_cnt;
    logic                  clk32k_fault;
    logic [2:0]            state_o;

    modport master (
        output pll_lock,
        output sw_rst_n,
        output clk32k_in,
        input  rst_n_out,
        input  sys_ready,
        input  lock_lost_cnt,
        input  clk32k_fault,
        input  state_o
    );

    modport slave (
        input  pll_lock,
        input  sw_rst_n,
        input  clk32k_in,
        output rst_n_out,
        output sys_ready,
        output lock_lost_cnt,
        output clk32k_fault,
        output state_o
    );
endinterface

// File: rtl/rst_seq_ctrl.sv
// Purpose : post-PLL reset sequencer. Qualifies lock, releases NUM_STAGES
//           domain resets in order with fixed gaps, raises sys_ready in RUN,
//           re-asserts everything on lock loss / software request, and
//           watches the 32 kHz clock for stalls while running.
// Ports   : clkin1   - system clock
//           pll_rst  - asynchronous active-low reset
//           bus      - rst_seq_if.slave: pll_lock, sw_rst_n, clk32k_in in;
//                      rst_n_out, sys_ready, lock_lost_cnt, clk32k_fault,
//                      state_o out (all registered)
module rst_seq_ctrl #(
    parameter int unsigned LOCK_STABLE_CYC = 1024,
    parameter int unsigned STAGE_GAP_CYC   = 256,
    parameter int unsigned NUM_STAGES      = 3,
    parameter int unsigned EDGE_TIMEOUT    = 4096,
    parameter int unsigned CNT_W           = 16
) (
    input  logic      clkin1,
    input  logic      pll_rst,
    rst_seq_if.slave  bus
);

    localparam logic [CNT_W-1:0] STAB_LAST = CNT_W'(LOCK_STABLE_CYC - 1);
    localparam logic [CNT_W-1:0] REL_LAST  = CNT_W'(NUM_STAGES * STAGE_GAP_CYC - 1);
    localparam logic [CNT_W-1:0] WD_LAST   = CNT_W'(EDGE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        STABLE  = 3'd1,
        RELEASE = 3'd2,
        RUN     = 3'd3,
        FAULT   = 3'd4
    } state_t;

    state_t                state_q,  state_d;
    logic [CNT_W-1:0]      stab_q,   stab_d;
    logic [CNT_W-1:0]      rel_q,    rel_d;
    logic [CNT_W-1:0]      wd_q,     wd_d;
    logic [NUM_STAGES-1:0] rst_n_q,  rst_n_d;
    logic                  ready_q,  ready_d;
    logic [7:0]            lost_q,   lost_d;
    logic                  fault_q,  fault_d;

    logic lock_m_q, lock_s_q;
    logic swr_m_q,  swr_s_q;
    logic c32_m_q,  c32_s_q, c32_d1_q;
    logic c32_rise_c;

    // Two-flop synchronizers plus a delay flop for clk32k edge detection
    always_ff @(posedge clkin1 or negedge pll_rst) begin
        if (!pll_rst) begin
            lock_m_q <= 1'b0;
            lock_s_q <= 1'b0;
            swr_m_q  <= 1'b0;
            swr_s_q  <= 1'b0;
            c32_m_q  <= 1'b0;
            c32_s_q  <= 1'b0;
            c32_d1_q <= 1'b0;
        end else begin
            lock_m_q <= bus.pll_lock;
            lock_s_q <= lock_m_q;
            swr_m_q  <= bus.sw_rst_n;
            swr_s_q  <= swr_m_q;
            c32_m_q  <= bus.clk32k_in;
            c32_s_q  <= c32_m_q;
            c32_d1_q <= c32_s_q;
        end
    end

    assign c32_rise_c = c32_s_q & ~c32_d1_q;

    // State, counters and registered outputs
    always_ff @(posedge clkin1 or negedge pll_rst) begin
        if (!pll_rst) begin
            state_q <= IDLE;
            stab_q  <= '0;
            rel_q   <= '0;
            wd_q    <= '0;
            rst_n_q <= '0;
            ready_q <= 1'b0;
            lost_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            stab_q  <= stab_d;
            rel_q   <= rel_d;
            wd_q    <= wd_d;
            rst_n_q <= rst_n_d;
            ready_q <= ready_d;
            lost_q  <= lost_d;
            fault_q <= fault_d;
        end
    end

    // Next-state, counter update, and output decode from the next state
    always_comb begin
        state_d = state_q;
        stab_d  = stab_q;
        rel_d   = rel_q;
        wd_d    = '0;
        rst_n_d = rst_n_q;
        ready_d = 1'b0;
        lost_d  = lost_q;
        fault_d = fault_q;

        unique case (state_q)
            IDLE: begin
                stab_d = '0;
                rel_d  = '0;
                if (lock_s_q && swr_s_q) state_d = STABLE;
            end
            STABLE: begin
                rel_d = '0;
                if (!lock_s_q || !swr_s_q) state_d = IDLE;
                else if (stab_q == STAB_LAST) state_d = RELEASE;
                else stab_d = stab_q + CNT_W'(1);
            end
            RELEASE, RUN: begin
                // Lock loss takes priority so a coincident sw request still counts
                if (!lock_s_q) begin
                    state_d = FAULT;
                    if (lost_q != 8'hFF) lost_d = lost_q + 8'd1;
                end else if (!swr_s_q) begin
                    state_d = FAULT;
                end else if (state_q == RELEASE) begin
                    if (rel_q == REL_LAST) state_d = RUN;
                    else rel_d = rel_q + CNT_W'(1);
                end else begin
                    // Watchdog saturates at the terminal value instead of wrapping
                    if (c32_rise_c)          wd_d = '0;
                    else if (wd_q == WD_LAST) wd_d = wd_q;
                    else                     wd_d = wd_q + CNT_W'(1);
                end
            end
            FAULT: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        unique case (state_d)
            IDLE: begin
                rst_n_d = '0;
                stab_d  = '0;
                rel_d   = '0;
                fault_d = 1'b0;
            end
            STABLE: rst_n_d = '0;
            RELEASE: begin
                // Stage k releases once k*STAGE_GAP_CYC cycles have elapsed
                for (int unsigned k = 0; k < NUM_STAGES; k++) begin
                    rst_n_d[k] = (rel_d >= CNT_W'(k * STAGE_GAP_CYC));
                end
            end
            RUN: begin
                rst_n_d = '1;
                ready_d = 1'b1;
                if (wd_d == WD_LAST) fault_d = 1'b1;
            end
            FAULT: rst_n_d = '0;
            default: rst_n_d = '0;
        endcase
    end

    assign bus.rst_n_out     = rst_n_q;
    assign bus.sys_ready     = ready_q;
    assign bus.lock_lost_cnt = lost_q;
    assign bus.clk32k_fault  = fault_q;
    assign bus.state_o       = state_q;

endmodule

// File: tb/tb_rst_seq_ctrl.sv
// Directed bench for rst_seq_ctrl with shortened timing parameters.
// Inputs change on the falling edge; outputs are sampled on the falling edge.
module tb_rst_seq_ctrl;

    logic clkin1 = 1'b0;
    logic pll_rst;

    always #5 clkin1 = ~clkin1;

    rst_seq_if #(.NUM_STAGES(3)) bus ();

    rst_seq_ctrl #(
        .LOCK_STABLE_CYC(8),
        .STAGE_GAP_CYC  (4),
        .NUM_STAGES     (3),
        .EDGE_TIMEOUT   (16),
        .CNT_W          (16)
    ) dut (
        .clkin1  (clkin1),
        .pll_rst (pll_rst),
        .bus     (bus)
    );

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;
    bit          tog_en      = 1'b0;
    int unsigned tog_ph      = 0;
    bit          rose        = 1'b0;

    // Advance to the next falling edge; optionally toggle clk32k every 5 cycles
    task automatic tick();
        @(negedge clkin1);
        rose = 1'b0;
        if (tog_en) begin
            tog_ph = tog_ph + 1;
            if (tog_ph == 5) begin
                tog_ph = 0;
                bus.clk32k_in = ~bus.clk32k_in;
                rose = bus.clk32k_in;
            end
        end
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors = vectors + 1;
        assert (obs === exp)
        else begin
            miscompares = miscompares + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive lock high (caller) and wait, bounded, for RUN
    task automatic bring_up();
        for (int i = 0; i < 100; i++) begin
            if (bus.state_o == 3'd3) break;
            tick();
        end
        chk("bringup_run", 32'(bus.state_o), 32'd3);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

    initial begin
        pll_rst       = 1'b0;
        bus.pll_lock  = 1'b0;
        bus.sw_rst_n  = 1'b1;
        bus.clk32k_in = 1'b0;
        #2;
        chk("rst_state", 32'(bus.state_o), 32'd0);
        chk("rst_rstn",  32'(bus.rst_n_out), 32'd0);
        chk("rst_ready", 32'(bus.sys_ready), 32'd0);
        chk("rst_cnt",   32'(bus.lock_lost_cnt), 32'd0);
        chk("rst_fault", 32'(bus.clk32k_fault), 32'd0);
        ticks(2);
        pll_rst = 1'b1;
        ticks(3);
        chk("idle_nolock", 32'(bus.state_o), 32'd0);

        // Nominal bring-up
        bus.pll_lock = 1'b1;
        ticks(2);
        chk("t1_sync_lat", 32'(bus.state_o), 32'd0);
        tick();
        chk("t1_stable", 32'(bus.state_o), 32'd1);
        ticks(7);
        chk("t1_stable_end", 32'(bus.state_o), 32'd1);
        chk("t1_rstn_held", 32'(bus.rst_n_out), 32'd0);
        tick();
        chk("t1_release", 32'(bus.state_o), 32'd2);
        chk("t1_rstn_001", 32'(bus.rst_n_out), 32'd1);
        ticks(3);
        chk("t1_rstn_001b", 32'(bus.rst_n_out), 32'd1);
        tick();
        chk("t1_rstn_011", 32'(bus.rst_n_out), 32'd3);
        ticks(4);
        chk("t1_rstn_111", 32'(bus.rst_n_out), 32'd7);
        chk("t1_notready", 32'(bus.sys_ready), 32'd0);
        ticks(3);
        chk("t1_still_rel", 32'(bus.state_o), 32'd2);
        tick();
        chk("t1_run", 32'(bus.state_o), 32'd3);
        chk("t1_ready", 32'(bus.sys_ready), 32'd1);

        // Lock loss in RUN
        bus.pll_lock = 1'b0;
        ticks(2);
        chk("t3_run_hold", 32'(bus.state_o), 32'd3);
        tick();
        chk("t3_fault", 32'(bus.state_o), 32'd4);
        chk("t3_rstn", 32'(bus.rst_n_out), 32'd0);
        chk("t3_ready", 32'(bus.sys_ready), 32'd0);
        chk("t3_cnt", 32'(bus.lock_lost_cnt), 32'd1);
        tick();
        chk("t3_idle", 32'(bus.state_o), 32'd0);

        // Lock glitch in STABLE, then full requalification
        bus.pll_lock = 1'b1;
        ticks(3);
        chk("t2_stable", 32'(bus.state_o), 32'd1);
        ticks(4);
        bus.pll_lock = 1'b0;
        ticks(3);
        chk("t2_idle", 32'(bus.state_o), 32'd0);
        chk("t2_cnt", 32'(bus.lock_lost_cnt), 32'd1);
        bus.pll_lock = 1'b1;
        ticks(3);
        chk("t2_restable", 32'(bus.state_o), 32'd1);
        ticks(7);
        chk("t2_full_qual", 32'(bus.state_o), 32'd1);
        tick();
        chk("t2_release", 32'(bus.rst_n_out), 32'd1);

        // Software reset in RELEASE with two stages out
        ticks(4);
        chk("t4_rstn_011", 32'(bus.rst_n_out), 32'd3);
        bus.sw_rst_n = 1'b0;
        ticks(3);
        chk("t4_fault", 32'(bus.state_o), 32'd4);
        chk("t4_rstn", 32'(bus.rst_n_out), 32'd0);
        chk("t4_cnt_same", 32'(bus.lock_lost_cnt), 32'd1);
        tick();
        chk("t4_idle", 32'(bus.state_o), 32'd0);
        bus.sw_rst_n = 1'b1;
        bring_up();
        bus.pll_lock = 1'b0;
        bus.sw_rst_n = 1'b0;
        ticks(3);
        chk("t4_both_fault", 32'(bus.state_o), 32'd4);
        chk("t4_both_cnt", 32'(bus.lock_lost_cnt), 32'd2);
        tick();
        bus.pll_lock = 1'b1;
        bus.sw_rst_n = 1'b1;

        // Clock monitor
        tog_en = 1'b1;
        tog_ph = 0;
        bring_up();
        ticks(40);
        chk("t5_no_fault", 32'(bus.clk32k_fault), 32'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rose) break;
        end
        chk("t5_rise_seen", 32'(rose), 32'd1);
        tog_en = 1'b0;
        ticks(3);
        bus.clk32k_in = 1'b0;
        ticks(14);
        chk("t5_fault_pre", 32'(bus.clk32k_fault), 32'd0);
        tick();
        chk("t5_fault_set", 32'(bus.clk32k_fault), 32'd1);
        chk("t5_rstn_kept", 32'(bus.rst_n_out), 32'd7);
        tog_en = 1'b1;
        ticks(30);
        chk("t5_sticky", 32'(bus.clk32k_fault), 32'd1);
        chk("t5_still_run", 32'(bus.state_o), 32'd3);
        bus.pll_lock = 1'b0;
        ticks(3);
        chk("t5_fault_st", 32'(bus.state_o), 32'd4);
        tick();
        chk("t5_idle", 32'(bus.state_o), 32'd0);
        chk("t5_fault_clr", 32'(bus.clk32k_fault), 32'd0);
        tog_en = 1'b0;
        bus.clk32k_in = 1'b0;

        // Saturate the lock-loss counter
        for (int n = 0; n < 300; n++) begin
            bus.pll_lock = 1'b1;
            bring_up();
            bus.pll_lock = 1'b0;
            ticks(4);
        end
        chk("t3_saturate", 32'(bus.lock_lost_cnt), 32'd255);

        // Asynchronous reset pulse mid-RELEASE
        bus.pll_lock = 1'b1;
        ticks(11);
        chk("t6_release", 32'(bus.state_o), 32'd2);
        chk("t6_rstn_001", 32'(bus.rst_n_out), 32'd1);
        #1 pll_rst = 1'b0;
        #1;
        chk("t6_state", 32'(bus.state_o), 32'd0);
        chk("t6_rstn", 32'(bus.rst_n_out), 32'd0);
        chk("t6_ready", 32'(bus.sys_ready), 32'd0);
        chk("t6_cnt", 32'(bus.lock_lost_cnt), 32'd0);
        chk("t6_fault", 32'(bus.clk32k_fault), 32'd0);
        #1 pll_rst = 1'b1;
        tick();
        chk("t6_resync", 32'(bus.state_o), 32'd0);
        ticks(2);
        chk("t6_restable", 32'(bus.state_o), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
